// File: rtl/mole_game_ctrl_if.sv
// Player-side signal bundle of the mole game controller: start/buttons in, display and counters out.
// The player (master) drives start/btn; the controller (slave) drives everything else.
interface mole_game_ctrl_if;
    logic       start;
    logic [7:0] btn;
    logic [7:0] random_num;
    logic [7:0] mole_hit;
    logic [7:0] score;
    logic [7:0] misses;
    logic       busy;

    modport master (
        output start,
        output btn,
        input  random_num,
        input  mole_hit,
        input  score,
        input  misses,
        input  busy
    );

    modport slave (
        input  start,
        input  btn,
        output random_num,
        output mole_hit,
        output score,
        output misses,
        output busy
    );
endinterface

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole round sequencer feeding the VGA square renderer: mole selection, timing, hits, score.
// Optional macro WRONG_PENALTY_EN: wrong-button rises in UP cost one point (saturating at 0).
module mole_game_ctrl #(
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned GAP_TICKS = 200,
    parameter int unsigned UP_TICKS  = 800,
    parameter int unsigned HIT_TICKS = 250,
    parameter int unsigned ROUNDS    = 30,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic            CLK,
    input  logic            RST_BTN,
    mole_game_ctrl_if.slave game_io
);

    localparam int unsigned MaxTicks =
        (GAP_TICKS > UP_TICKS) ? ((GAP_TICKS > HIT_TICKS) ? GAP_TICKS : HIT_TICKS)
                               : ((UP_TICKS > HIT_TICKS) ? UP_TICKS : HIT_TICKS);
    localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TickW  = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
    localparam int unsigned RoundW = $clog2(ROUNDS + 1);

    localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_DIV - 1);
    localparam logic [TickW-1:0]  GapLast   = TickW'(GAP_TICKS - 1);
    localparam logic [TickW-1:0]  UpLast    = TickW'(UP_TICKS - 1);
    localparam logic [TickW-1:0]  HitLast   = TickW'(HIT_TICKS - 1);
    localparam logic [RoundW-1:0] RoundLast = RoundW'(ROUNDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGap,
        StUp,
        StHit
    } state_e;

    state_e            state_q, state_d;
    logic [PrescW-1:0] presc_q, presc_d;
    logic [TickW-1:0]  tick_q, tick_d;
    logic [RoundW-1:0] round_q, round_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic              start_q;
    logic [7:0]        btn_q;
    logic [2:0]        idx_q, idx_d;
    logic              idx_valid_q, idx_valid_d;
    logic [7:0]        random_num_q, random_num_d;
    logic [7:0]        mole_hit_q, mole_hit_d;
    logic [7:0]        score_q, score_d;
    logic [7:0]        misses_q, misses_d;
    logic              busy_q, busy_d;

    logic              start_rise;
    logic [7:0]        btn_rise;
    logic              tick;
    logic [TickW-1:0]  tick_limit;
    logic              state_done;
    logic [2:0]        pick_raw;
    logic [2:0]        pick_idx;
    logic              hit_now;
    logic              wrong_now;
    logic              last_round;
    logic [RoundW-1:0] round_inc;
    logic [7:0]        score_inc;
    logic [7:0]        score_dec;
    logic [7:0]        misses_inc;

    assign start_rise = game_io.start & ~start_q;
    assign btn_rise   = game_io.btn & ~btn_q;

    // x^8+x^6+x^5+x^4+1; never locks up because the seed is nonzero and it never stops
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    assign tick = (presc_q == PrescLast);

    always_comb begin
        tick_limit = '0;
        unique case (state_q)
            StGap:   tick_limit = GapLast;
            StUp:    tick_limit = UpLast;
            StHit:   tick_limit = HitLast;
            default: tick_limit = '0;
        endcase
    end

    assign state_done = tick && (tick_q == tick_limit);

    // Avoid showing the same square twice in a row
    assign pick_raw = lfsr_q[2:0];
    assign pick_idx = (idx_valid_q && (pick_raw == idx_q)) ? pick_raw + 3'd1 : pick_raw;

    assign hit_now = btn_rise[idx_q];
`ifdef WRONG_PENALTY_EN
    assign wrong_now = |(btn_rise & ~random_num_q);
`else
    assign wrong_now = 1'b0;
`endif

    assign last_round = (round_q == RoundLast);
    assign round_inc  = round_q + RoundW'(1);
    assign score_inc  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
    assign score_dec  = (score_q == 8'h00) ? score_q : score_q - 8'd1;
    assign misses_inc = (misses_q == 8'hFF) ? misses_q : misses_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        idx_d        = idx_q;
        idx_valid_d  = idx_valid_q;
        random_num_d = random_num_q;
        mole_hit_d   = mole_hit_q;
        score_d      = score_q;
        misses_d     = misses_q;
        busy_d       = busy_q;

        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    state_d     = StGap;
                    score_d     = 8'd0;
                    misses_d    = 8'd0;
                    round_d     = '0;
                    busy_d      = 1'b1;
                    idx_valid_d = 1'b0;
                end
            end
            StGap: begin
                if (state_done) begin
                    state_d      = StUp;
                    idx_d        = pick_idx;
                    idx_valid_d  = 1'b1;
                    random_num_d = 8'd1 << pick_idx;
                end
            end
            StUp: begin
                // A hit in the timeout cycle still counts as a hit
                if (hit_now) begin
                    state_d      = StHit;
                    random_num_d = 8'd0;
                    mole_hit_d   = 8'd1 << idx_q;
                end else if (state_done) begin
                    state_d      = last_round ? StIdle : StGap;
                    busy_d       = !last_round;
                    random_num_d = 8'd0;
                    misses_d     = misses_inc;
                    round_d      = round_inc;
                end
                if (hit_now && !wrong_now) begin
                    score_d = score_inc;
                end else if (wrong_now && !hit_now) begin
                    score_d = score_dec;
                end
            end
            StHit: begin
                if (state_done) begin
                    state_d    = last_round ? StIdle : StGap;
                    busy_d     = !last_round;
                    mole_hit_d = 8'd0;
                    round_d    = round_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Prescaler and tick counter restart on every state entry; idle keeps them parked at zero
    always_comb begin
        presc_d = '0;
        tick_d  = '0;
        if ((state_d == state_q) && (state_q != StIdle)) begin
            presc_d = tick ? '0 : presc_q + PrescW'(1);
            tick_d  = tick ? tick_q + TickW'(1) : tick_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            state_q      <= StIdle;
            presc_q      <= '0;
            tick_q       <= '0;
            round_q      <= '0;
            lfsr_q       <= LFSR_SEED;
            start_q      <= 1'b0;
            btn_q        <= 8'd0;
            idx_q        <= 3'd0;
            idx_valid_q  <= 1'b0;
            random_num_q <= 8'd0;
            mole_hit_q   <= 8'd0;
            score_q      <= 8'd0;
            misses_q     <= 8'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            tick_q       <= tick_d;
            round_q      <= round_d;
            lfsr_q       <= lfsr_d;
            start_q      <= game_io.start;
            btn_q        <= game_io.btn;
            idx_q        <= idx_d;
            idx_valid_q  <= idx_valid_d;
            random_num_q <= random_num_d;
            mole_hit_q   <= mole_hit_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            busy_q       <= busy_d;
        end
    end

    assign game_io.random_num = random_num_q;
    assign game_io.mole_hit   = mole_hit_q;
    assign game_io.score      = score_q;
    assign game_io.misses     = misses_q;
    assign game_io.busy       = busy_q;

    a_mole_onehot0: assert property (@(posedge CLK) disable iff (!RST_BTN)
        $onehot0(random_num_q));
    a_hit_onehot0: assert property (@(posedge CLK) disable iff (!RST_BTN)
        $onehot0(mole_hit_q));
    a_no_overlap: assert property (@(posedge CLK) disable iff (!RST_BTN)
        (random_num_q & mole_hit_q) == 8'd0);

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: a table of directed rounds plus randomized play, all checked every
// cycle against a cycle-countdown reference model of the game rules.
module tb_mole_game_ctrl;

    localparam int unsigned TD    = 4;
    localparam int unsigned GAPT  = 3;
    localparam int unsigned UPT   = 5;
    localparam int unsigned HITT  = 2;
    localparam int unsigned RND   = 3;
    localparam logic [7:0]  SEED  = 8'hA5;
    localparam int GAP_CYC = GAPT * TD;
    localparam int UP_CYC  = UPT * TD;
    localparam int HIT_CYC = HITT * TD;

    localparam int PIdle = 0;
    localparam int PGap  = 1;
    localparam int PUp   = 2;
    localparam int PHit  = 3;

    localparam int ActHit       = 0;
    localparam int ActMiss      = 1;
    localparam int ActWrongMiss = 2;
    localparam int ActHitWrong  = 3;

`ifdef WRONG_PENALTY_EN
    localparam logic [7:0] ScoreAfterWrong = 8'd0;
    localparam logic [7:0] ScoreGame2End   = 8'd0;
`else
    localparam logic [7:0] ScoreAfterWrong = 8'd1;
    localparam logic [7:0] ScoreGame2End   = 8'd2;
`endif

    logic CLK = 1'b0;
    logic RST_BTN;

    mole_game_ctrl_if game ();

    mole_game_ctrl #(
        .TICK_DIV  (TD),
        .GAP_TICKS (GAPT),
        .UP_TICKS  (UPT),
        .HIT_TICKS (HITT),
        .ROUNDS    (RND),
        .LFSR_SEED (SEED)
    ) dut (
        .CLK     (CLK),
        .RST_BTN (RST_BTN),
        .game_io (game)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int         m_phase;
    int         m_left;
    int         m_idx;
    int         m_round;
    bit         m_have_prev;
    logic [7:0] m_lfsr;
    logic [7:0] m_rn;
    logic [7:0] m_mh;
    logic [7:0] m_score;
    logic [7:0] m_misses;
    logic       m_busy;
    logic       m_sp;
    logic [7:0] m_bp;

    typedef struct {
        int         act;
        bit         new_game;
        logic [7:0] exp_score;
        logic [7:0] exp_misses;
        logic       exp_busy;
        logic [7:0] exp_mid;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase     = PIdle;
        m_left      = 0;
        m_idx       = 0;
        m_round     = 0;
        m_have_prev = 1'b0;
        m_lfsr      = SEED;
        m_rn        = 8'd0;
        m_mh        = 8'd0;
        m_score     = 8'd0;
        m_misses    = 8'd0;
        m_busy      = 1'b0;
        m_sp        = 1'b0;
        m_bp        = 8'd0;
    endtask

    task automatic model_end_round();
        m_round++;
        if (m_round == int'(RND)) begin
            m_phase = PIdle;
            m_busy  = 1'b0;
        end else begin
            m_phase = PGap;
            m_left  = GAP_CYC;
        end
    endtask

    // One clock edge of the game rules, with phase lengths as plain cycle countdowns
    task automatic model_step();
        logic       rs;
        logic [7:0] rb;
        bit         hit;
        bit         wrong;
        int         sc;
        int         idx;
        rs = game.start & ~m_sp;
        rb = game.btn & ~m_bp;
        case (m_phase)
            PIdle: begin
                if (rs) begin
                    m_phase     = PGap;
                    m_left      = GAP_CYC;
                    m_score     = 8'd0;
                    m_misses    = 8'd0;
                    m_round     = 0;
                    m_busy      = 1'b1;
                    m_have_prev = 1'b0;
                end
            end
            PGap: begin
                m_left--;
                if (m_left == 0) begin
                    idx = int'(m_lfsr[2:0]);
                    if (m_have_prev && idx == m_idx) idx = (idx + 1) % 8;
                    m_idx       = idx;
                    m_have_prev = 1'b1;
                    m_rn        = 8'(1 << idx);
                    m_phase     = PUp;
                    m_left      = UP_CYC;
                end
            end
            PUp: begin
                hit = rb[m_idx];
`ifdef WRONG_PENALTY_EN
                wrong = ((rb & ~m_rn) != 8'd0);
`else
                wrong = 1'b0;
`endif
                sc = int'(m_score) + (hit ? 1 : 0) - (wrong ? 1 : 0);
                if (sc < 0) sc = 0;
                if (sc > 255) sc = 255;
                m_left--;
                if (hit) begin
                    m_rn    = 8'd0;
                    m_mh    = 8'(1 << m_idx);
                    m_phase = PHit;
                    m_left  = HIT_CYC;
                end else if (m_left == 0) begin
                    m_rn = 8'd0;
                    if (m_misses != 8'hFF) m_misses = m_misses + 8'd1;
                    model_end_round();
                end
                m_score = 8'(sc);
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    m_mh = 8'd0;
                    model_end_round();
                end
            end
        endcase
        m_sp   = game.start;
        m_bp   = game.btn;
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
    endtask

    task automatic check_model();
        chk("random_num", 32'(game.random_num), 32'(m_rn));
        chk("mole_hit", 32'(game.mole_hit), 32'(m_mh));
        chk("score", 32'(game.score), 32'(m_score));
        chk("misses", 32'(game.misses), 32'(m_misses));
        chk("busy", 32'(game.busy), 32'(m_busy));
        chk("no_overlap", 32'(game.random_num & game.mole_hit), 32'd0);
    endtask

    // Advance one clock: model steps on the edge, outputs compared on the falling edge
    task automatic cyc();
        @(posedge CLK);
        if (RST_BTN) model_step();
        @(negedge CLK);
        check_model();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         n;
        logic [7:0] oh;
        logic [7:0] prev_oh;
        logic [7:0] wrong_oh;
        int         r;

        vecs[0] = '{ActHit,       1'b1, 8'd1,            8'd0, 1'b1, 8'd0};
        vecs[1] = '{ActMiss,      1'b0, 8'd1,            8'd1, 1'b1, 8'd0};
        vecs[2] = '{ActHit,       1'b0, 8'd2,            8'd1, 1'b0, 8'd0};
        vecs[3] = '{ActHit,       1'b1, 8'd1,            8'd0, 1'b1, 8'd0};
        vecs[4] = '{ActWrongMiss, 1'b0, ScoreAfterWrong, 8'd1, 1'b1, ScoreAfterWrong};
        vecs[5] = '{ActHitWrong,  1'b0, ScoreGame2End,   8'd1, 1'b0, 8'd0};

        game.start = 1'b0;
        game.btn   = 8'd0;
        RST_BTN    = 1'b1;
        model_reset();
        #1 RST_BTN = 1'b0;

        // Inputs toggling under reset must not disturb anything
        for (int i = 0; i < 6; i++) begin
            game.start = i[0];
            game.btn   = 8'($urandom);
            cyc();
            chk("rst_random_num", 32'(game.random_num), 32'd0);
            chk("rst_busy", 32'(game.busy), 32'd0);
            chk("rst_score", 32'(game.score), 32'd0);
        end
        game.start = 1'b0;
        game.btn   = 8'd0;
        RST_BTN    = 1'b1;
        cyc();

        prev_oh = 8'd0;
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].new_game) begin
                game.start = 1'b1;
                cyc();
                game.start = 1'b0;
                chk("start_busy", 32'(game.busy), 32'd1);
                chk("start_score", 32'(game.score), 32'd0);
                chk("start_misses", 32'(game.misses), 32'd0);
                prev_oh = 8'd0;
            end
            n = 0;
            while (game.random_num == 8'd0 && n < 100) begin
                cyc();
                n++;
            end
            chk("gap_cycles", 32'(n), 32'(GAP_CYC));
            oh = game.random_num;
            chk("mole_onehot", 32'($onehot(oh)), 32'd1);
            chk("mole_hit_clear", 32'(game.mole_hit), 32'd0);
            if (prev_oh != 8'd0) chk("mole_differs", 32'(oh != prev_oh), 32'd1);
            prev_oh  = oh;
            wrong_oh = {oh[6:0], oh[7]};

            if (vecs[v].act == ActHit || vecs[v].act == ActHitWrong) begin
                game.btn = (vecs[v].act == ActHit) ? oh : (oh | wrong_oh);
                cyc();
                game.btn = 8'd0;
                chk("hit_random_num", 32'(game.random_num), 32'd0);
                chk("hit_mole_hit", 32'(game.mole_hit), 32'(oh));
                n = 0;
                while (game.mole_hit != 8'd0 && n < 100) begin
                    n++;
                    cyc();
                end
                chk("hit_cycles", 32'(n), 32'(HIT_CYC));
            end else begin
                n = 0;
                if (vecs[v].act == ActMiss) begin
                    game.start = 1'b1;
                    cyc();
                    game.start = 1'b0;
                    n = 1;
                end else begin
                    game.btn = wrong_oh;
                    cyc();
                    game.btn = 8'd0;
                    chk("wrong1_score", 32'(game.score), 32'(vecs[v].exp_mid));
                    cyc();
                    game.btn = wrong_oh;
                    cyc();
                    game.btn = 8'd0;
                    chk("wrong2_score", 32'(game.score), 32'(vecs[v].exp_mid));
                    n = 3;
                end
                while (game.random_num != 8'd0 && n < 100) begin
                    cyc();
                    n++;
                end
                chk("up_cycles", 32'(n), 32'(UP_CYC));
                chk("miss_mole_hit", 32'(game.mole_hit), 32'd0);
            end
            chk("row_score", 32'(game.score), 32'(vecs[v].exp_score));
            chk("row_misses", 32'(game.misses), 32'(vecs[v].exp_misses));
            chk("row_busy", 32'(game.busy), 32'(vecs[v].exp_busy));
        end

        // Counters hold after the game ends
        repeat (5) cyc();
        chk("hold_score", 32'(game.score), 32'(ScoreGame2End));
        chk("hold_misses", 32'(game.misses), 32'd1);

        // Asynchronous reset while a mole is up
        game.start = 1'b1;
        cyc();
        game.start = 1'b0;
        n = 0;
        while (game.random_num == 8'd0 && n < 100) begin
            cyc();
            n++;
        end
        chk("pre_rst_mole", 32'($onehot(game.random_num)), 32'd1);
        cyc();
        #2 RST_BTN = 1'b0;
        #1;
        model_reset();
        chk("async_rst_random_num", 32'(game.random_num), 32'd0);
        chk("async_rst_busy", 32'(game.busy), 32'd0);
        chk("async_rst_score", 32'(game.score), 32'd0);
        cyc();
        cyc();
        RST_BTN = 1'b1;

        // Randomized play
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                #2 RST_BTN = 1'b0;
                #1;
                model_reset();
                check_model();
                cyc();
                RST_BTN = 1'b1;
            end
            game.start = ($urandom_range(0, 24) == 0);
            r = int'($urandom_range(0, 99));
            if (r < 15)      game.btn = m_rn;
            else if (r < 22) game.btn = 8'($urandom);
            else if (r < 30) game.btn = m_rn | 8'(1 << $urandom_range(0, 7));
            else             game.btn = 8'd0;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
